// File: rtl/instruction_type_pkg.sv
// Shared instruction encodings used by the control-flow resolution logic.
// Holds the RISC-V opcode constants and the branch funct3 encoding.
package instruction_type;

   localparam logic [6:0] J_FORMAT    = 7'b1101111;
   localparam logic [6:0] JALR_FORMAT = 7'b1100111;
   localparam logic [6:0] B_FORMAT    = 7'b1100011;

   typedef enum logic [2:0] {
      BEQ  = 3'b000,
      BNE  = 3'b001,
      BLT  = 3'b100,
      BGE  = 3'b101,
      BLTU = 3'b110,
      BGEU = 3'b111
   } branch_funct3_t;

   function automatic logic is_control_flow(input logic [6:0] opcode);
      return (opcode == J_FORMAT) || (opcode == JALR_FORMAT) || (opcode == B_FORMAT);
   endfunction

endpackage

// File: rtl/branch_comparator.sv
// Combinational taken/not-taken decision for jumps and conditional branches.
// Zero latency; no flow control.
module branch_comparator
   import instruction_type::*;
(
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   output logic        taken
);

   always_comb begin
      taken = 1'b0;
      if (opcode == J_FORMAT || opcode == JALR_FORMAT) begin
         taken = 1'b1;
      end else if (opcode == B_FORMAT) begin
         case (funct3)
            BEQ:     taken = (rs1 == rs2);
            BNE:     taken = (rs1 != rs2);
            BLT:     taken = ($signed(rs1) <  $signed(rs2));
            BGE:     taken = ($signed(rs1) >= $signed(rs2));
            BLTU:    taken = (rs1 <  rs2);
            BGEU:    taken = (rs1 >= rs2);
            default: taken = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/branch_resolver.sv
// Resolves the held EX control-flow entry, reports the outcome and redirects fetch on mispredict.
// Outputs one cycle after resolution; stall holds the entry and defers resolution (ignored while flushing).
module branch_resolver
   import instruction_type::*;
#(
   parameter int PC_SIZE      = 12,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               stall,
   input  logic               id_valid,
   input  logic [6:0]         id_opcode,
   input  logic [2:0]         id_funct3,
   input  logic [PC_SIZE-1:0] id_pc,
   input  logic [PC_SIZE-1:0] id_imm,
   input  logic               id_pred_taken,
   input  logic [PC_SIZE-1:0] id_pred_pc,
   input  logic [31:0]        ex_rs1,
   input  logic [31:0]        ex_rs2,
   output logic               should_have_jumped,
   output logic               redirect_valid,
   output logic [PC_SIZE-1:0] redirect_pc,
   output logic               flush_nop,
   output logic [15:0]        branch_count,
   output logic [15:0]        mispredict_count
);

   localparam int CW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

   typedef enum logic {RUN, FLUSH} state_t;

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt, cnt_nxt;

   logic                ex_valid;
   logic [6:0]          ex_opcode;
   logic [2:0]          ex_funct3;
   logic [PC_SIZE-1:0]  ex_pc;
   logic [PC_SIZE-1:0]  ex_imm;
   logic                ex_pred_taken;
   logic [PC_SIZE-1:0]  ex_pred_pc;

   logic                resolve;
   logic                taken;
   logic                mispredict;
   logic [PC_SIZE-1:0]  target;
   logic [PC_SIZE-1:0]  jalr_sum;

   branch_comparator u_cmp (
      .opcode (ex_opcode),
      .funct3 (ex_funct3),
      .rs1    (ex_rs1),
      .rs2    (ex_rs2),
      .taken  (taken)
   );

   assign resolve    = ex_valid && !stall && (state == RUN);
   assign jalr_sum   = ex_rs1[PC_SIZE-1:0] + ex_imm;
   assign mispredict = resolve && ((ex_pred_taken != taken) || (ex_pred_pc != target));
   assign flush_nop  = (state == FLUSH);

   always_comb begin
      target = ex_pc + PC_SIZE'(4);
      if (ex_opcode == JALR_FORMAT) begin
         target = {jalr_sum[PC_SIZE-1:1], 1'b0};
      end else if (taken) begin
         target = ex_pc + ex_imm;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         RUN: begin
            if (mispredict) begin
               state_nxt = FLUSH;
               cnt_nxt   = CW'(FLUSH_CYCLES);
            end
         end
         FLUSH: begin
            cnt_nxt = cnt - CW'(1);
            if (cnt == CW'(1)) state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // The entry keeps loading even on a mispredict; the FLUSH cycle that follows invalidates it.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ex_valid <= 1'b0;
      end else if (state == FLUSH) begin
         ex_valid <= 1'b0;
      end else if (!stall) begin
         ex_valid <= id_valid;
      end
   end

   always_ff @(posedge CLK) begin
      if (state == RUN && !stall) begin
         ex_opcode     <= id_opcode;
         ex_funct3     <= id_funct3;
         ex_pc         <= id_pc;
         ex_imm        <= id_imm;
         ex_pred_taken <= id_pred_taken;
         ex_pred_pc    <= id_pred_pc;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         should_have_jumped <= 1'b0;
         redirect_valid     <= 1'b0;
         redirect_pc        <= '0;
         branch_count       <= '0;
         mispredict_count   <= '0;
      end else begin
         should_have_jumped <= resolve && taken;
         redirect_valid     <= mispredict;
         if (mispredict) redirect_pc <= target;
         if (resolve && is_control_flow(ex_opcode) && branch_count != 16'hFFFF)
            branch_count <= branch_count + 16'd1;
         if (mispredict && mispredict_count != 16'hFFFF)
            mispredict_count <= mispredict_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level reference model.
module tb_branch_resolver;

   localparam int PCS = 12;
   localparam int FC  = 2;

   localparam logic [6:0] OP_B    = 7'h63;
   localparam logic [6:0] OP_JAL  = 7'h6F;
   localparam logic [6:0] OP_JALR = 7'h67;

   logic            CLK = 1'b0;
   logic            RESET;
   logic            stall;
   logic            id_valid;
   logic [6:0]      id_opcode;
   logic [2:0]      id_funct3;
   logic [PCS-1:0]  id_pc;
   logic [PCS-1:0]  id_imm;
   logic            id_pred_taken;
   logic [PCS-1:0]  id_pred_pc;
   logic [31:0]     ex_rs1;
   logic [31:0]     ex_rs2;
   logic            should_have_jumped;
   logic            redirect_valid;
   logic [PCS-1:0]  redirect_pc;
   logic            flush_nop;
   logic [15:0]     branch_count;
   logic [15:0]     mispredict_count;

   branch_resolver #(.PC_SIZE(PCS), .FLUSH_CYCLES(FC)) dut (
      .CLK                (CLK),
      .RESET              (RESET),
      .stall              (stall),
      .id_valid           (id_valid),
      .id_opcode          (id_opcode),
      .id_funct3          (id_funct3),
      .id_pc              (id_pc),
      .id_imm             (id_imm),
      .id_pred_taken      (id_pred_taken),
      .id_pred_pc         (id_pred_pc),
      .ex_rs1             (ex_rs1),
      .ex_rs2             (ex_rs2),
      .should_have_jumped (should_have_jumped),
      .redirect_valid     (redirect_valid),
      .redirect_pc        (redirect_pc),
      .flush_nop          (flush_nop),
      .branch_count       (branch_count),
      .mispredict_count   (mispredict_count)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Reference model: the instruction waiting for EX and how many bubble cycles remain.
   logic            m_valid = 1'b0;
   logic [6:0]      m_op = '0;
   logic [2:0]      m_f3 = '0;
   logic [PCS-1:0]  m_pc = '0, m_imm = '0, m_ppc = '0;
   logic            m_pt = 1'b0;
   int              flush_left = 0;
   int              m_bc = 0, m_mc = 0;
   logic            exp_shj = 1'b0, exp_rv = 1'b0;
   logic [PCS-1:0]  exp_rpc = '0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic void ref_outcome(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [PCS-1:0] pc, input logic [PCS-1:0] imm,
                                       input logic [31:0] a, input logic [31:0] b,
                                       output logic tk, output logic [PCS-1:0] tgt);
      logic [PCS-1:0] sum;
      tk = 1'b0;
      if (op == OP_JAL || op == OP_JALR) tk = 1'b1;
      else if (op == OP_B) begin
         case (f3)
            3'd0: tk = (a == b);
            3'd1: tk = (a != b);
            3'd4: tk = ($signed(a) <  $signed(b));
            3'd5: tk = ($signed(a) >= $signed(b));
            3'd6: tk = (a <  b);
            3'd7: tk = (a >= b);
            default: tk = 1'b0;
         endcase
      end
      sum = a[PCS-1:0] + imm;
      if (op == OP_JALR) tgt = sum & 12'hFFE;
      else if (tk)       tgt = pc + imm;
      else               tgt = pc + 12'd4;
   endfunction

   task automatic model_step();
      logic tk, mis;
      logic [PCS-1:0] tgt;
      exp_shj = 1'b0;
      exp_rv  = 1'b0;
      if (RESET) begin
         m_valid = 1'b0; flush_left = 0; m_bc = 0; m_mc = 0; exp_rpc = '0;
      end else if (flush_left > 0) begin
         flush_left--;
         m_valid = 1'b0;
      end else begin
         if (m_valid && !stall) begin
            ref_outcome(m_op, m_f3, m_pc, m_imm, ex_rs1, ex_rs2, tk, tgt);
            exp_shj = tk;
            mis = (m_pt != tk) || (m_ppc != tgt);
            if ((m_op == OP_B || m_op == OP_JAL || m_op == OP_JALR) && m_bc < 65535) m_bc++;
            if (mis) begin
               exp_rv = 1'b1; exp_rpc = tgt; flush_left = FC;
               if (m_mc < 65535) m_mc++;
            end
         end
         if (!stall) begin
            m_valid = id_valid; m_op = id_opcode; m_f3 = id_funct3;
            m_pc = id_pc; m_imm = id_imm; m_pt = id_pred_taken; m_ppc = id_pred_pc;
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge CLK);
      #1;
      check("should_have_jumped", 32'(should_have_jumped), 32'(exp_shj));
      check("redirect_valid", 32'(redirect_valid), 32'(exp_rv));
      if (exp_rv) check("redirect_pc", 32'(redirect_pc), 32'(exp_rpc));
      check("flush_nop", 32'(flush_nop), 32'(flush_left > 0));
      check("branch_count", 32'(branch_count), 32'(m_bc));
      check("mispredict_count", 32'(mispredict_count), 32'(m_mc));
   endtask

   task automatic set_id(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [PCS-1:0] pc, input logic [PCS-1:0] imm,
                         input logic pt, input logic [PCS-1:0] ppc);
      id_valid = v; id_opcode = op; id_funct3 = f3; id_pc = pc;
      id_imm = imm; id_pred_taken = pt; id_pred_pc = ppc;
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      RESET = 1'b1; stall = 1'b0; ex_rs1 = '0; ex_rs2 = '0;
      set_id(1'b0, 7'd0, 3'd0, '0, '0, 1'b0, '0);
      tick();
      tick();
      check("reset_flush_nop", 32'(flush_nop), 32'd0);
      check("reset_branch_count", 32'(branch_count), 32'd0);
      RESET = 1'b0;

      // BEQ correctly predicted taken
      set_id(1'b1, OP_B, 3'd0, 12'h010, 12'h020, 1'b1, 12'h030);
      ex_rs1 = 32'd5; ex_rs2 = 32'd5;
      tick();
      set_id(1'b0, 7'd0, 3'd0, '0, '0, 1'b0, '0);
      tick();
      check("beq_shj", 32'(should_have_jumped), 32'd1);
      check("beq_no_redirect", 32'(redirect_valid), 32'd0);
      check("beq_branch_count", 32'(branch_count), 32'd1);

      // BLT predicted not taken but taken
      set_id(1'b1, OP_B, 3'd4, 12'h010, 12'h040, 1'b0, 12'h014);
      ex_rs1 = 32'hFFFF_FFFF; ex_rs2 = 32'd1;
      tick();
      set_id(1'b0, 7'd0, 3'd0, '0, '0, 1'b0, '0);
      tick();
      check("blt_redirect_valid", 32'(redirect_valid), 32'd1);
      check("blt_redirect_pc", 32'(redirect_pc), 32'h050);
      check("blt_flush_1", 32'(flush_nop), 32'd1);
      check("blt_mispredict_count", 32'(mispredict_count), 32'd1);
      tick();
      check("blt_flush_2", 32'(flush_nop), 32'd1);
      tick();
      check("blt_flush_end", 32'(flush_nop), 32'd0);

      // JALR redirect; the wrong-path JAL behind it must never be counted
      set_id(1'b1, OP_JALR, 3'd0, 12'h300, 12'h004, 1'b1, 12'h200);
      ex_rs1 = 32'h101; ex_rs2 = 32'd0;
      tick();
      set_id(1'b1, OP_JAL, 3'd0, 12'h104, 12'h008, 1'b0, 12'h108);
      tick();
      check("jalr_redirect_pc", 32'(redirect_pc), 32'h104);
      set_id(1'b0, 7'd0, 3'd0, '0, '0, 1'b0, '0);
      repeat (4) tick();
      check("jalr_discard_bc", 32'(branch_count), 32'd3);
      check("jalr_discard_mc", 32'(mispredict_count), 32'd2);

      // BNE mispredict held under stall for three cycles
      set_id(1'b1, OP_B, 3'd1, 12'h020, 12'h010, 1'b0, 12'h024);
      ex_rs1 = 32'd1; ex_rs2 = 32'd2;
      tick();
      set_id(1'b0, 7'd0, 3'd0, '0, '0, 1'b0, '0);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bne_stalled_no_redirect", 32'(redirect_valid), 32'd0);
      end
      stall = 1'b0;
      tick();
      check("bne_redirect_valid", 32'(redirect_valid), 32'd1);
      check("bne_redirect_pc", 32'(redirect_pc), 32'h030);
      repeat (3) tick();
      check("bne_mc_once", 32'(mispredict_count), 32'd3);
      check("bne_bc", 32'(branch_count), 32'd4);

      // Reset in the second flush cycle
      set_id(1'b1, OP_B, 3'd4, 12'h010, 12'h040, 1'b0, 12'h014);
      ex_rs1 = 32'hFFFF_FFFF; ex_rs2 = 32'd1;
      tick();
      set_id(1'b0, 7'd0, 3'd0, '0, '0, 1'b0, '0);
      tick();
      tick();
      check("rst_pre_flush2", 32'(flush_nop), 32'd1);
      RESET = 1'b1;
      tick();
      check("rst_flush_nop", 32'(flush_nop), 32'd0);
      check("rst_bc", 32'(branch_count), 32'd0);
      check("rst_mc", 32'(mispredict_count), 32'd0);
      RESET = 1'b0;
      set_id(1'b1, OP_B, 3'd0, 12'h040, 12'h008, 1'b1, 12'h048);
      ex_rs1 = 32'd7; ex_rs2 = 32'd7;
      tick();
      set_id(1'b0, 7'd0, 3'd0, '0, '0, 1'b0, '0);
      tick();
      check("rst_run_shj", 32'(should_have_jumped), 32'd1);
      check("rst_run_bc", 32'(branch_count), 32'd1);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         logic [PCS-1:0] pc, imm;
         RESET = ($urandom_range(0, 199) == 0);
         stall = ($urandom_range(0, 4) == 0);
         pc  = 12'($urandom);
         imm = 12'($urandom);
         id_valid = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 4))
            0, 1: id_opcode = OP_B;
            2:    id_opcode = OP_JAL;
            3:    id_opcode = OP_JALR;
            default: id_opcode = 7'($urandom);
         endcase
         id_funct3 = 3'($urandom);
         id_pc = pc;
         id_imm = imm;
         id_pred_taken = 1'($urandom);
         case ($urandom_range(0, 2))
            0: id_pred_pc = pc + 12'd4;
            1: id_pred_pc = pc + imm;
            default: id_pred_pc = 12'($urandom);
         endcase
         ex_rs1 = pick_operand();
         ex_rs2 = pick_operand();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter PC_SIZE, default 12, is the width of all PC and target fields.
REQ-002 Parameter FLUSH_CYCLES, default 2, is the number of bubble cycles inserted after a redirect.
REQ-003 CLK  in  1  is the single clock; all state updates on its rising edge.
REQ-004 RESET  in  1  is the reset: synchronous, active-high.
REQ-005 stall  in  1  holds the ID->EX entry and suppresses resolution.
REQ-006 id_valid  in  1  means an instruction is present in ID.
REQ-007 id_opcode  in  7  is the ID instruction opcode.
REQ-008 id_funct3  in  3  is the ID instruction funct3.
REQ-009 id_pc  in  PC_SIZE  is the ID instruction address.
REQ-010 id_imm  in  PC_SIZE  is the sign-truncated branch/jump byte offset.
REQ-011 id_pred_taken  in  1  is the fetch-time prediction for this instruction.
REQ-012 id_pred_pc  in  PC_SIZE  is the PC fetched after this instruction.
REQ-013 ex_rs1, ex_rs2  in  32 each  are the forwarded EX operands for the held entry.
REQ-014 should_have_jumped  out  1  is the registered actual outcome, returned to the predictor.
REQ-015 redirect_valid  out  1  is a one-cycle pulse requesting a fetch redirect.
REQ-016 redirect_pc  out  PC_SIZE  is the corrected fetch address, valid with redirect_valid.
REQ-017 flush_nop  out  1  means IF/ID contents are to be replaced by NOPs.
REQ-018 branch_count, mispredict_count  out  16 each  are saturating statistics counters.

Function
REQ-019 The EX entry {valid, opcode, funct3, pc, imm, pred_taken, pred_pc} loads from ID when stall=0 and state RUN, loads valid=0 in state FLUSH, and holds when stall=1.
REQ-020 An entry is resolved once, in the cycle it is valid with stall=0 and state RUN.
REQ-021 Taken: JAL and JALR always; B_FORMAT per funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 and all other opcodes not taken.
REQ-022 Actual target: JALR (ex_rs1[PC_SIZE-1:0]+imm) with bit0 cleared; JAL/B pc+imm; not taken pc+4; all sums modulo 2^PC_SIZE.
REQ-023 Mispredict = resolved and (pred_taken != taken, or pred_pc != actual target).
REQ-024 Outputs are registered: one cycle after resolution, should_have_jumped=taken, and on mispredict redirect_valid=1 with redirect_pc=actual target; otherwise redirect_valid=0.
REQ-025 FSM states RUN and FLUSH; RUN->FLUSH on mispredict, loading a counter with FLUSH_CYCLES; FLUSH decrements each cycle and returns to RUN as the counter reaches 1.
REQ-026 flush_nop is high for exactly FLUSH_CYCLES consecutive cycles, starting the cycle redirect_valid is high.
REQ-027 In FLUSH no resolution occurs; should_have_jumped is 0; stall is ignored.
REQ-028 branch_count increments per resolved JAL/JALR/B entry; mispredict_count increments per mispredict; both saturate at 0xFFFF.
REQ-029 Mispredict while stall=1 is deferred until the first cycle with stall=0.

Reset
REQ-030 RESET=1 at a clock edge sets state RUN, entry valid=0, all outputs and counters 0; RESET overrides every simultaneous event, including mid-flush.

Structure
REQ-031 Opcode constants (J_FORMAT, B_FORMAT, JALR_FORMAT) and a branch funct3 enum live in the shared instruction_type package; the RUN/FLUSH enum is local.
REQ-032 The comparison of REQ-021 is a combinational sub-module named branch_comparator.

Verification
REQ-033 BEQ at pc 0x010, imm 0x020, rs1=rs2=5, pred_taken=1, pred_pc 0x030 -> no redirect, should_have_jumped=1, branch_count=1.
REQ-034 BLT rs1=-1, rs2=1, pred_taken=0, pred_pc 0x014 at pc 0x010, imm 0x040 -> redirect_pc 0x050, flush_nop for 2 cycles, mispredict_count=1.
REQ-035 JALR rs1=0x101, imm 0x004, pred_pc 0x200 -> redirect_pc 0x104; the following ID entry is discarded.
REQ-036 BNE mispredict with stall held 3 cycles -> redirect_valid only after stall drops, counted once.
REQ-037 RESET asserted during the second flush cycle -> next cycle flush_nop=0, counters 0, state RUN.
